// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
package seg7_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'b00,
        HOLD      = 2'b01,
        OFF       = 2'b10,
        LAMP_TEST = 2'b11
    } mode_e;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    // Nibble that lights every segment of the decoder (digit "8").
    localparam logic [3:0] LAMP_NIBBLE = 4'h8;

endpackage

// File: rtl/seg7_scan_mux_tick_prescaler.sv
// Free-running phase prescaler: one tick every PRESCALE enabled clocks.
module tick_prescaler #(
    parameter int PRESCALE = 1024
) (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    // Tick marks the last cycle of a phase; it is gated by ena so a frozen
    // scanner never sees a boundary.
    assign tick = ena && (count == LAST);

    // Count 0..PRESCALE-1 while enabled, wrapping on the tick cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (ena) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed digit scanner: snapshots a word of nibbles, walks the
// digits with a blanking phase between them and drives the 7-seg decoder.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int PRESCALE   = 1024,
    localparam int DATA_W     = 4 * NUM_DIGITS,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic [IDX_W-1:0]      hold_sel,
    output logic [3:0]            nibble,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic                  tick;
    logic [DATA_W-1:0]     shadow;
    logic [NUM_DIGITS-1:0] shadow_dp;
    mode_e                 mode_q;
    logic [IDX_W-1:0]      sel_q;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      show_idx;
    state_e                state;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .tick (tick)
    );

    // HOLD pins the scan to the sampled selection; other modes walk idx.
    assign show_idx = (mode_q == HOLD) ? sel_q : idx;

    // Shadow capture. The FSM reads the pre-load value on the same edge, so a
    // load coinciding with a SHOW entry only affects later digits.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else if (ena && load) begin
            shadow    <= data_in;
            shadow_dp <= dp_in;
        end
    end

    // Phase FSM with registered decoder outputs; mode/hold_sel are sampled
    // on each tick and acted upon at the following phase boundary.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_q     <= SCAN;
            sel_q      <= '0;
            idx        <= '0;
            state      <= BLANK;
            nibble     <= '0;
            dp         <= 1'b0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else if (ena) begin
            frame_done <= 1'b0;
            if (tick) begin
                mode_q <= mode_e'(mode);
                sel_q  <= hold_sel;
                if (mode_q == OFF) begin
                    state    <= BLANK;
                    idx      <= '0;
                    nibble   <= '0;
                    dp       <= 1'b0;
                    digit_en <= '0;
                end else if (state == BLANK) begin
                    state <= SHOW;
                    idx   <= show_idx;
                    if (mode_q == LAMP_TEST) begin
                        nibble   <= LAMP_NIBBLE;
                        dp       <= 1'b1;
                        digit_en <= '1;
                    end else begin
                        nibble   <= shadow[{show_idx, 2'b00} +: 4];
                        dp       <= shadow_dp[show_idx];
                        digit_en <= ONE_HOT0 << show_idx;
                    end
                end else begin
                    state    <= BLANK;
                    digit_en <= '0;
                    if (mode_q != HOLD) begin
                        idx <= idx + 1'b1;
                    end
                    frame_done <= (mode_q == SCAN) && (idx == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised and directed bench for seg7_scan_mux against a phase-level model.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int DW = 4 * ND;

    logic          clk      = 1'b0;
    logic          rstb     = 1'b0;
    logic          ena      = 1'b0;
    logic          load     = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic [ND-1:0] dp_in    = '0;
    logic [1:0]    mode     = 2'b00;
    logic [1:0]    hold_sel = 2'b00;
    logic [3:0]    nibble;
    logic          dp;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model state: enabled-cycle phase count, lit flag, digit
    // position, sampled mode/selection and the snapshot words.
    int            m_cnt;
    int            m_pos;
    int            m_mode;
    int            m_sel;
    bit            m_show;
    logic [DW-1:0] m_shadow;
    logic [ND-1:0] m_dps;
    logic [3:0]    e_nib;
    logic          e_dp;
    logic [ND-1:0] e_en;
    logic          e_fd;

    logic [3:0]    scan_tab [ND];
    int            first;
    int            last_ev;
    int            seen;
    int            waited;
    logic [3:0]    sv_nib;
    logic [ND-1:0] sv_en;
    logic          sv_dp;
    logic [ND-1:0] prev_en;

    seg7_scan_mux #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .mode       (mode),
        .hold_sel   (hold_sel),
        .nibble     (nibble),
        .dp         (dp),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_pos    = 0;
        m_mode   = 0;
        m_sel    = 0;
        m_show   = 1'b0;
        m_shadow = '0;
        m_dps    = '0;
        e_nib    = '0;
        e_dp     = 1'b0;
        e_en     = '0;
        e_fd     = 1'b0;
    endtask

    // One enabled clock: every PS-th one is a phase boundary.
    task automatic model_step();
        bit tick;
        if (!ena) return;
        tick  = (m_cnt == PS - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        e_fd  = 1'b0;
        if (tick) begin
            if (m_mode == 2) begin
                m_show = 1'b0;
                m_pos  = 0;
                e_nib  = '0;
                e_dp   = 1'b0;
                e_en   = '0;
            end else if (!m_show) begin
                m_show = 1'b1;
                if (m_mode == 1) m_pos = m_sel;
                if (m_mode == 3) begin
                    e_nib = 4'h8;
                    e_dp  = 1'b1;
                    e_en  = '1;
                end else begin
                    e_nib = 4'((m_shadow >> (4 * m_pos)) & DW'(15));
                    e_dp  = m_dps[m_pos];
                    e_en  = ND'(1) << m_pos;
                end
            end else begin
                m_show = 1'b0;
                e_en   = '0;
                if (m_mode == 0 && m_pos == ND - 1) e_fd = 1'b1;
                if (m_mode != 1) m_pos = (m_pos + 1) % ND;
            end
            m_mode = int'(mode);
            m_sel  = int'(hold_sel);
        end
        if (load) begin
            m_shadow = data_in;
            m_dps    = dp_in;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cycle++;
        chk("nibble", 32'(nibble), 32'(e_nib));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("digit_en", 32'(digit_en), 32'(e_en));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic latency_check(input string tag);
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i < 4) chk({tag, "_dark"}, 32'(digit_en), 32'd0);
            if (i == 4) chk({tag, "_lit"}, 32'(digit_en), 32'b0001);
            if (first < 0 && digit_en != '0) first = i;
        end
        chk({tag, "_cycles"}, 32'(first), 32'd4);
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic [ND-1:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        cyc();
        load    = 1'b0;
    endtask

    initial begin
        scan_tab[0] = 4'h3;
        scan_tab[1] = 4'hC;
        scan_tab[2] = 4'h5;
        scan_tab[3] = 4'hA;
        model_reset();
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nibble", 32'(nibble), 32'd0);
        chk("rst_en", 32'(digit_en), 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        rstb = 1'b1;
        latency_check("lat");

        // SCAN of A5C3 with dp on digit 2.
        load_word(16'hA5C3, 4'b0100);
        last_ev = -1;
        for (int i = 0; i < 80; i++) begin
            cyc();
            for (int k = 0; k < ND; k++) begin
                if (digit_en == ND'(1 << k)) begin
                    chk("scan_nib", 32'(nibble), 32'(scan_tab[k]));
                    chk("scan_dp", 32'(dp), (k == 2) ? 32'd1 : 32'd0);
                end
            end
            if (frame_done) begin
                if (last_ev >= 0) chk("fd_period", 32'(cycle - last_ev), 32'd32);
                last_ev = cycle;
            end
        end
        chk("fd_seen", 32'(last_ev >= 0), 32'd1);

        // Asynchronous reset in the middle of a SHOW phase.
        waited = 0;
        while (digit_en == '0 && waited < 20) begin
            cyc();
            waited++;
        end
        chk("wait_show", 32'(digit_en != '0), 32'd1);
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_nib", 32'(nibble), 32'd0);
        chk("rst_mid_en", 32'(digit_en), 32'd0);
        chk("rst_mid_dp", 32'(dp), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        latency_check("lat2");
        load_word(16'hA5C3, 4'b0100);

        // HOLD on digit 2: only 0100 lights, blinking every 2*PS clocks.
        mode     = 2'b01;
        hold_sel = 2'd2;
        repeat (24) cyc();
        last_ev = -1;
        prev_en = digit_en;
        for (int i = 0; i < 48; i++) begin
            cyc();
            if (digit_en != '0) begin
                chk("hold_en", 32'(digit_en), 32'b0100);
                chk("hold_nib", 32'(nibble), 32'h5);
            end
            if (prev_en == '0 && digit_en != '0) begin
                if (last_ev >= 0) chk("hold_period", 32'(cycle - last_ev), 32'd8);
                last_ev = cycle;
            end
            prev_en = digit_en;
        end

        // OFF, then LAMP_TEST.
        mode = 2'b10;
        repeat (16) cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("off_en", 32'(digit_en), 32'd0);
            chk("off_nib", 32'(nibble), 32'd0);
        end
        mode = 2'b11;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (digit_en != '0) begin
                seen++;
                chk("lamp_en", 32'(digit_en), 32'hF);
                chk("lamp_nib", 32'(nibble), 32'h8);
                chk("lamp_dp", 32'(dp), 32'd1);
            end
        end
        chk("lamp_seen", 32'(seen > 0), 32'd1);

        // Load on the very tick that enters SHOW of digit 1.
        mode = 2'b00;
        repeat (16) cyc();
        waited = 0;
        while (!(m_mode == 0 && !m_show && m_pos == 1 && m_cnt == PS - 1) && waited < 64) begin
            cyc();
            waited++;
        end
        chk("wait_bnd", 32'(waited < 64), 32'd1);
        load_word(16'h1234, 4'b0000);
        chk("bnd_en", 32'(digit_en), 32'b0010);
        chk("bnd_old", 32'(nibble), 32'hC);
        waited = 0;
        while (digit_en != 4'b0100 && waited < 40) begin
            cyc();
            waited++;
        end
        chk("bnd_new_en", 32'(digit_en), 32'b0100);
        chk("bnd_new", 32'(nibble), 32'h2);

        // Freeze mid-SHOW for 10 clocks, then finish the phase.
        waited = 0;
        while (!(m_show && m_cnt == 1) && waited < 40) begin
            cyc();
            waited++;
        end
        sv_nib = nibble;
        sv_en  = digit_en;
        sv_dp  = dp;
        ena    = 1'b0;
        load_word(16'hFFFF, 4'b1111);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("frz_en", 32'(digit_en), 32'(sv_en));
            chk("frz_nib", 32'(nibble), 32'(sv_nib));
            chk("frz_dp", 32'(dp), 32'(sv_dp));
        end
        ena   = 1'b1;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (first < 0 && digit_en == '0) first = i;
        end
        chk("frz_resume", 32'(first), 32'd3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            ena      = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 15) == 0);
            data_in  = DW'($urandom);
            dp_in    = ND'($urandom);
            hold_sel = 2'($urandom);
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom);
            cyc();
        end
        load = 1'b0;
        ena  = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
